// File: rtl/layer_pkg.sv
// Shared types and defaults for the inter-layer link of the Morse decoder net.
// Optional drop counter is enabled by defining LAYER_LINK_DROP_CNT_EN.
package layer_pkg;

    localparam int unsigned LL_N_CH_DEF = 4;
    localparam int unsigned LL_W_DEF    = 8;
    localparam int unsigned DROP_CNT_W  = 8;

    typedef enum logic [0:0] {
        StCollect,
        StFull
    } ll_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/layer_link_chan.sv
// One channel of the capture bank: a W-bit activation register and its "reported" bit.
// Clear takes priority over load so an abort or transfer always empties the slot.
module layer_link_chan
    import layer_pkg::*;
#(
    parameter int unsigned W = LL_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] data,
    output logic         valid
);

    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            data_d  = din;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/layer_link.sv
// Double-buffered link: collects one activation per channel, then publishes the frame
// over valid/ready. Define LAYER_LINK_DROP_CNT_EN to add the saturating drop_cnt port.
module layer_link
    import layer_pkg::*;
#(
    parameter int unsigned N_CH = LL_N_CH_DEF,
    parameter int unsigned W    = LL_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_frame,
    input  logic [N_CH*W-1:0]     in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH*W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef LAYER_LINK_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    ll_state_e           state_q, state_d;
    logic [N_CH*W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;

    logic [N_CH*W-1:0]   cap_data;
    logic [N_CH*W-1:0]   merged;
    logic [N_CH-1:0]     mask;
    logic [N_CH-1:0]     mask_next;
    logic [N_CH-1:0]     chan_load;
    logic                chan_clear;
    logic                out_free;
    logic                transfer;

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        layer_link_chan #(
            .W (W)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .load  (chan_load[c]),
            .clear (chan_clear),
            .din   (in_data[c*W +: W]),
            .data  (cap_data[c*W +: W]),
            .valid (mask[c])
        );
    end

    always_comb begin
        out_free  = !out_valid_q || out_ready;
        chan_load = (state_q == StCollect && !new_frame) ? in_valid : '0;
        mask_next = mask | chan_load;

        // Frame as it will stand after this edge, so completion can transfer immediately.
        merged = cap_data;
        for (int c = 0; c < N_CH; c++) begin
            if (chan_load[c]) begin
                merged[c*W +: W] = in_data[c*W +: W];
            end
        end

        transfer = 1'b0;
        state_d  = state_q;
        unique case (state_q)
            StCollect: begin
                if (!new_frame && (&mask_next)) begin
                    if (out_free) begin
                        transfer = 1'b1;
                    end else begin
                        state_d = StFull;
                    end
                end
            end
            StFull: begin
                if (new_frame) begin
                    state_d = StCollect;
                end else if (out_free) begin
                    transfer = 1'b1;
                    state_d  = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase

        chan_clear = new_frame || transfer;

        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (transfer) begin
            out_data_d  = merged;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StCollect;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

`ifdef LAYER_LINK_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic                  dropped;

    // One count per cycle in which any strobe is discarded, however many bits were set.
    assign dropped = (|in_valid) && (new_frame || state_q == StFull);

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (dropped) begin
            drop_cnt_q <= sat_inc(drop_cnt_q);
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_layer_link.sv
// Scoreboard bench for layer_link at three sizes (4x8, 1x3, 8x16).
// Drop counter checks are included when LAYER_LINK_DROP_CNT_EN is defined.
module tb_layer_link;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // DUT A: 4 channels x 8 bits
    logic        a_reset, a_new_frame, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [3:0]  a_in_valid;
    // DUT B: 1 channel x 3 bits
    logic        bc_reset;
    logic        b_new_frame, b_out_valid, b_out_ready;
    logic [2:0]  b_in_data, b_out_data;
    logic [0:0]  b_in_valid;
    // DUT C: 8 channels x 16 bits
    logic         c_new_frame, c_out_valid, c_out_ready;
    logic [127:0] c_in_data, c_out_data;
    logic [7:0]   c_in_valid;
`ifdef LAYER_LINK_DROP_CNT_EN
    logic [7:0] a_drop_cnt, b_drop_cnt, c_drop_cnt;
`endif

    logic [127:0] a_q[$];
    logic [127:0] b_q[$];
    logic [127:0] c_q[$];

    layer_link #(.N_CH(4), .W(8)) u_dut_a (
        .clk       (clk),
        .reset     (a_reset),
        .new_frame (a_new_frame),
        .in_data   (a_in_data),
        .in_valid  (a_in_valid),
        .out_data  (a_out_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready)
`ifdef LAYER_LINK_DROP_CNT_EN
        ,
        .drop_cnt  (a_drop_cnt)
`endif
    );

    layer_link #(.N_CH(1), .W(3)) u_dut_b (
        .clk       (clk),
        .reset     (bc_reset),
        .new_frame (b_new_frame),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready)
`ifdef LAYER_LINK_DROP_CNT_EN
        ,
        .drop_cnt  (b_drop_cnt)
`endif
    );

    layer_link #(.N_CH(8), .W(16)) u_dut_c (
        .clk       (clk),
        .reset     (bc_reset),
        .new_frame (c_new_frame),
        .in_data   (c_in_data),
        .in_valid  (c_in_valid),
        .out_data  (c_out_data),
        .out_valid (c_out_valid),
        .out_ready (c_out_ready)
`ifdef LAYER_LINK_DROP_CNT_EN
        ,
        .drop_cnt  (c_drop_cnt)
`endif
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: every accepted output beat is popped against the scoreboard.
    always @(negedge clk) begin
        if (!a_reset && a_out_valid && a_out_ready) begin
            if (a_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL a_unexpected_frame: got %0h, expected no frame", a_out_data);
            end else begin
                check("a_frame", {96'b0, a_out_data}, a_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!bc_reset && b_out_valid && b_out_ready) begin
            if (b_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b_unexpected_frame: got %0h, expected no frame", b_out_data);
            end else begin
                check("b_frame", {125'b0, b_out_data}, b_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!bc_reset && c_out_valid && c_out_ready) begin
            if (c_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL c_unexpected_frame: got %0h, expected no frame", c_out_data);
            end else begin
                check("c_frame", c_out_data, c_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        a_reset = 1'b1; a_new_frame = 1'b0; a_in_data = '0; a_in_valid = '0; a_out_ready = 1'b0;
        bc_reset = 1'b1;
        b_new_frame = 1'b0; b_in_data = '0; b_in_valid = '0; b_out_ready = 1'b0;
        c_new_frame = 1'b0; c_in_data = '0; c_in_valid = '0; c_out_ready = 1'b0;
        step();
        a_in_valid = 4'hF; a_in_data = 32'hDEADBEEF;  // strobes under reset must be ignored
        step();
        step();
        a_reset = 1'b0; bc_reset = 1'b0; a_in_valid = '0;
        check("reset_a_valid", {127'b0, a_out_valid}, 128'd0);
        check("reset_a_data", {96'b0, a_out_data}, 128'd0);
        check("reset_c_valid", {127'b0, c_out_valid}, 128'd0);

        // 1: in-order strobes
        a_out_ready = 1'b1;
        a_in_valid = 4'b0001; a_in_data = 32'h00000011; step();
        a_in_valid = 4'b0010; a_in_data = 32'h00002200; step();
        check("t1_not_early", {127'b0, a_out_valid}, 128'd0);
        a_in_valid = 4'b0100; a_in_data = 32'h00330000; step();
        a_in_valid = 4'b1000; a_in_data = 32'h44000000;
        a_q.push_back(128'h44332211);
        step();
        check("t1_latency", {127'b0, a_out_valid}, 128'd1);
        a_in_valid = '0;
        step();
        check("t1_popped", {127'b0, a_out_valid}, 128'd0);

        // 2: overwrite then simultaneous completion
        a_in_valid = 4'b0010; a_in_data = 32'h00000500; step();
        a_in_valid = 4'b0010; a_in_data = 32'h00000900; step();
        a_in_valid = 4'b1101; a_in_data = 32'hA3A2FFA0;
        a_q.push_back(128'hA3A209A0);
        step();
        check("t2_latency", {127'b0, a_out_valid}, 128'd1);
        a_in_valid = '0;
        step();

        // 3: backpressure with frame A held, frame B parked in FULL
        a_out_ready = 1'b0;
        a_in_valid = 4'hF; a_in_data = 32'h01020304; a_q.push_back(128'h01020304); step();
        a_in_valid = 4'hF; a_in_data = 32'hB0B1B2B3; a_q.push_back(128'hB0B1B2B3); step();
        check("t3_hold_a", {96'b0, a_out_data}, 128'h01020304);
        a_in_valid = 4'hF; a_in_data = 32'hEEEEEEEE; step();
        a_in_valid = 4'b0100; step();
        check("t3_a_stable", {96'b0, a_out_data}, 128'h01020304);
        check("t3_a_valid", {127'b0, a_out_valid}, 128'd1);
        a_in_valid = '0; a_out_ready = 1'b1;
        step();
        check("t3_b_published", {96'b0, a_out_data}, 128'hB0B1B2B3);
        step();
        check("t3_drained", {127'b0, a_out_valid}, 128'd0);
`ifdef LAYER_LINK_DROP_CNT_EN
        check("t3_drop_cnt", {120'b0, a_drop_cnt}, 128'd2);
`endif

        // 4: abort drops partial frame and the same-cycle strobe
        a_in_valid = 4'b0011; a_in_data = 32'h00005251; step();
        a_new_frame = 1'b1; a_in_valid = 4'b0100; a_in_data = 32'h00530000; step();
        a_new_frame = 1'b0;
        a_in_valid = 4'b1100; a_in_data = 32'h64630000; step();
        check("t4_mask_cleared", {127'b0, a_out_valid}, 128'd0);
        a_in_valid = 4'b0011; a_in_data = 32'h00006261; a_q.push_back(128'h64636261);
        step();
        check("t4_complete", {127'b0, a_out_valid}, 128'd1);
        a_in_valid = '0;
        step();
`ifdef LAYER_LINK_DROP_CNT_EN
        check("t4_drop_cnt", {120'b0, a_drop_cnt}, 128'd3);
`endif

        // 5: reset mid-frame while a frame is published
        a_out_ready = 1'b0;
        a_in_valid = 4'hF; a_in_data = 32'h0A0B0C0D; step();
        check("t5_pre_valid", {127'b0, a_out_valid}, 128'd1);
        a_in_valid = 4'b0001; a_in_data = 32'h00000077; step();
        a_in_valid = '0; a_reset = 1'b1; step();
        check("t5_reset_valid", {127'b0, a_out_valid}, 128'd0);
        check("t5_reset_data", {96'b0, a_out_data}, 128'd0);
        a_reset = 1'b0; a_out_ready = 1'b1;
        a_in_valid = 4'b1110; a_in_data = 32'h83828100; step();
        check("t5_needs_all", {127'b0, a_out_valid}, 128'd0);
        a_in_valid = 4'b0001; a_in_data = 32'h00000080; a_q.push_back(128'h83828180);
        step();
        check("t5_fresh_frame", {127'b0, a_out_valid}, 128'd1);
        a_in_valid = '0;
        step();
`ifdef LAYER_LINK_DROP_CNT_EN
        check("t5_drop_cleared", {120'b0, a_drop_cnt}, 128'd0);

        // drop counter saturation
        a_out_ready = 1'b0;
        a_in_valid = 4'hF; a_in_data = 32'h11111111; a_q.push_back(128'h11111111); step();
        a_in_valid = 4'hF; a_in_data = 32'h22222222; a_q.push_back(128'h22222222); step();
        a_in_valid = 4'h1;
        for (int i = 0; i < 260; i++) step();
        check("sat_drop_cnt", {120'b0, a_drop_cnt}, 128'd255);
        a_in_valid = '0; a_out_ready = 1'b1;
        step();
        step();
`endif

        // 6a: N_CH=1, W=3
        b_out_ready = 1'b1;
        b_in_valid = 1'b1; b_in_data = 3'd5; b_q.push_back(128'd5); step();
        check("b_latency", {127'b0, b_out_valid}, 128'd1);
        b_in_data = 3'd6; b_q.push_back(128'd6); step();
        check("b_back_to_back", {125'b0, b_out_data}, 128'd6);
        b_in_valid = 1'b0; step();
        check("b_popped", {127'b0, b_out_valid}, 128'd0);
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_data = 3'd1; b_q.push_back(128'd1); step();
        b_in_data = 3'd2; b_q.push_back(128'd2); step();
        b_in_data = 3'd7; step();
        check("b_hold", {125'b0, b_out_data}, 128'd1);
        b_in_valid = 1'b0; b_out_ready = 1'b1; step();
        check("b_second", {125'b0, b_out_data}, 128'd2);
        step();
        check("b_drained", {127'b0, b_out_valid}, 128'd0);

        // 6b: N_CH=8, W=16
        c_out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            c_in_valid = 8'(1 << c);
            c_in_data = '0;
            c_in_data[c*16 +: 16] = 16'((c + 1) * 16'h0101);
            if (c == 7) c_q.push_back(128'h0808_0707_0606_0505_0404_0303_0202_0101);
            step();
            if (c == 6) check("c_not_early", {127'b0, c_out_valid}, 128'd0);
        end
        check("c_latency", {127'b0, c_out_valid}, 128'd1);
        c_in_valid = '0; step();
        c_out_ready = 1'b0;
        c_in_valid = 8'hFF;
        for (int c = 0; c < 8; c++) c_in_data[c*16 +: 16] = 16'(16'hA000 + c);
        c_q.push_back(128'hA007_A006_A005_A004_A003_A002_A001_A000);
        step();
        for (int c = 0; c < 8; c++) c_in_data[c*16 +: 16] = 16'(16'hB000 + c);
        c_q.push_back(128'hB007_B006_B005_B004_B003_B002_B001_B000);
        step();
        c_in_data = '1; step();
        check("c_hold", c_out_data, 128'hA007_A006_A005_A004_A003_A002_A001_A000);
        c_in_valid = '0; c_out_ready = 1'b1; step();
        check("c_second", c_out_data, 128'hB007_B006_B005_B004_B003_B002_B001_B000);
        step();
        check("c_drained", {127'b0, c_out_valid}, 128'd0);
`ifdef LAYER_LINK_DROP_CNT_EN
        check("c_drop_cnt", {120'b0, c_drop_cnt}, 128'd1);
`endif

        step();
        check("a_queue_empty", 128'(a_q.size()), 128'd0);
        check("b_queue_empty", 128'(b_q.size()), 128'd0);
        check("c_queue_empty", 128'(c_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
